// File: rtl/dma_line_controller_if.sv
// Bundles the CPU command, bus arbitration, device and memory signals of the
// DMA line controller. The controller uses the master view; its environment
// (CPU, device and memory models) uses the slave view.
interface dma_line_controller_if #(
  parameter int WORD_SIZE      = 16,
  parameter int LINE_WORDS     = 4,
  parameter int DEVICE_BIT_LEN = 2
);
  logic                             cmd_valid;
  logic [WORD_SIZE-1:0]             cmd_addr;
  logic [WORD_SIZE-1:0]             cmd_length;
  logic                             busy;
  logic                             cmd_error;
  logic                             br;
  logic                             bg;
  logic [DEVICE_BIT_LEN-1:0]        offset;
  logic [LINE_WORDS*WORD_SIZE-1:0]  dev_data;
  logic                             mem_write;
  logic [WORD_SIZE-1:0]             mem_addr;
  logic [LINE_WORDS*WORD_SIZE-1:0]  mem_wdata;
  logic                             mem_ack;
  logic                             dma_end;

  modport master (
    input  cmd_valid, cmd_addr, cmd_length, bg, dev_data, mem_ack,
    output busy, cmd_error, br, offset, mem_write, mem_addr, mem_wdata, dma_end
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_length, bg, dev_data, mem_ack,
    input  busy, cmd_error, br, offset, mem_write, mem_addr, mem_wdata, dma_end
  );
endinterface

// File: rtl/dma_line_controller.sv
// DMA line controller: copies whole device lines into memory for the CPU.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for a command; offset parked (all ones)
//   REQ   | br raised, waiting for bg; offset is driven once bg arrives
//   SETUP | one settle cycle for device data; capture line if still granted
//   WRITE | mem_write held with stable address/data until mem_ack
//   DONE  | single cycle with dma_end high, bus already released
//
// Every output is registered: the comb process computes next values and the
// sequential process loads them.
module dma_line_controller #(
  parameter int WORD_SIZE      = 16,
  parameter int LINE_WORDS     = 4,
  parameter int NUM_LINES      = 3,
  parameter int DEVICE_BIT_LEN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  dma_line_controller_if.master  bus
);

  localparam logic [WORD_SIZE-1:0]      LINE_W  = WORD_SIZE'(LINE_WORDS);
  localparam logic [WORD_SIZE-1:0]      MAX_LEN = WORD_SIZE'(LINE_WORDS * NUM_LINES);
  localparam logic [DEVICE_BIT_LEN-1:0] PARKED  = '1;

  typedef enum logic [2:0] {IDLE, REQ, SETUP, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic                            busy_nxt, cmd_error_nxt, br_nxt;
  logic                            mem_write_nxt, dma_end_nxt;
  logic [DEVICE_BIT_LEN-1:0]       offset_nxt;
  logic [WORD_SIZE-1:0]            mem_addr_nxt;
  logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata_nxt;

  // transfer context: base address, index of the final line, current line
  logic [WORD_SIZE-1:0]      base, base_nxt;
  logic [DEVICE_BIT_LEN-1:0] last_idx, last_idx_nxt;
  logic [DEVICE_BIT_LEN-1:0] idx, idx_nxt;

  logic [DEVICE_BIT_LEN-1:0] idx_inc;
  logic [WORD_SIZE-1:0]      idx_ext;
  logic                      len_ok;

  assign idx_inc = idx + 1'b1;
  assign idx_ext = WORD_SIZE'(idx);
  assign len_ok  = (bus.cmd_length != '0) &&
                   ((bus.cmd_length % LINE_W) == '0) &&
                   (bus.cmd_length <= MAX_LEN);

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.cmd_error <= 1'b0;
      bus.br        <= 1'b0;
      bus.offset    <= PARKED;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.dma_end   <= 1'b0;
      base          <= '0;
      last_idx      <= '0;
      idx           <= '0;
    end else begin
      state         <= state_nxt;
      bus.busy      <= busy_nxt;
      bus.cmd_error <= cmd_error_nxt;
      bus.br        <= br_nxt;
      bus.offset    <= offset_nxt;
      bus.mem_write <= mem_write_nxt;
      bus.mem_addr  <= mem_addr_nxt;
      bus.mem_wdata <= mem_wdata_nxt;
      bus.dma_end   <= dma_end_nxt;
      base          <= base_nxt;
      last_idx      <= last_idx_nxt;
      idx           <= idx_nxt;
    end
  end

  // next-state and next-output decode; pulses default low, levels hold
  always_comb begin
    state_nxt     = state;
    busy_nxt      = bus.busy;
    cmd_error_nxt = 1'b0;
    br_nxt        = bus.br;
    offset_nxt    = bus.offset;
    mem_write_nxt = bus.mem_write;
    mem_addr_nxt  = bus.mem_addr;
    mem_wdata_nxt = bus.mem_wdata;
    dma_end_nxt   = 1'b0;
    base_nxt      = base;
    last_idx_nxt  = last_idx;
    idx_nxt       = idx;

    // a command while a transfer is running is refused without disturbing it
    if (bus.cmd_valid && (state != IDLE)) begin
      cmd_error_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (len_ok) begin
            base_nxt     = bus.cmd_addr;
            last_idx_nxt = DEVICE_BIT_LEN'((bus.cmd_length / LINE_W) - 1'b1);
            idx_nxt      = '0;
            br_nxt       = 1'b1;
            busy_nxt     = 1'b1;
            state_nxt    = REQ;
          end else begin
            cmd_error_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus.bg) begin
          offset_nxt = idx;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (bus.bg) begin
          mem_wdata_nxt = bus.dev_data;
          mem_addr_nxt  = base + idx_ext * LINE_W;
          mem_write_nxt = 1'b1;
          state_nxt     = WRITE;
        end else begin
          // grant withdrawn before the capture: retry the same line
          state_nxt = REQ;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          mem_write_nxt = 1'b0;
          if (idx == last_idx) begin
            br_nxt      = 1'b0;
            dma_end_nxt = 1'b1;
            offset_nxt  = PARKED;
            state_nxt   = DONE;
          end else begin
            idx_nxt    = idx_inc;
            offset_nxt = idx_inc;
            state_nxt  = SETUP;
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_line_controller.sv
// Directed bench for dma_line_controller with a write scoreboard, an
// auto-acknowledging memory model and a device model returning per-line
// patterns.
module tb_dma_line_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dma_line_controller_if bus ();

  dma_line_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  off;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;
  int end_cnt = 0;
  int dev_seed = 0;
  int ack_delay = 2;
  int ack_cnt = 0;
  logic auto_ack = 1'b0;
  logic stray_ack = 1'b0;
  logic wr_prev = 1'b0;
  logic end_prev = 1'b0;
  logic [79:0] held;

  function automatic logic [63:0] dev_line(input int off, input int seed);
    logic [63:0] v;
    for (int w = 0; w < 4; w++) begin
      v[w*16 +: 16] = {4'(seed), 4'(off), 8'(w * 17 + 3)};
    end
    return v;
  endfunction

  // device returns a seed/offset-dependent line; parked offset reads as 0
  always_comb begin
    bus.dev_data = '0;
    if (bus.offset < 2'd3) bus.dev_data = dev_line(int'(bus.offset), dev_seed);
  end

  always_comb bus.mem_ack = auto_ack | stray_ack;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory model: ack ack_delay cycles after each mem_write rise
  always @(negedge clk) begin
    auto_ack = 1'b0;
    if (reset) begin
      ack_cnt = 0;
    end else begin
      if (bus.mem_write && !wr_prev) ack_cnt = ack_delay;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) auto_ack = 1'b1;
      end
    end
  end

  // scoreboard and dma_end monitor
  always @(negedge clk) begin
    if (reset) begin
      wr_prev  = 1'b0;
      end_prev = 1'b0;
    end else begin
      if (bus.mem_write && !wr_prev) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected observed addr=%0h expected no write", bus.mem_addr);
        end
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("wr_addr", 80'(bus.mem_addr), 80'(e.addr));
          chk("wr_data", 80'(bus.mem_wdata), 80'(e.data));
          chk("wr_offset", 80'(bus.offset), 80'(e.off));
        end
        held = {bus.mem_addr, bus.mem_wdata};
      end else if (bus.mem_write && wr_prev) begin
        chk("wr_hold", {bus.mem_addr, bus.mem_wdata}, held);
      end
      if (bus.dma_end) begin
        end_cnt++;
        chk("end_br_low", 80'(bus.br), 80'(0));
      end
      if (end_prev) begin
        chk("end_busy_next", 80'(bus.busy), 80'(0));
        chk("end_single", 80'(bus.dma_end), 80'(0));
      end
      wr_prev  = bus.mem_write;
      end_prev = bus.dma_end;
    end
  end

  task automatic send_cmd(input logic [15:0] addr, input logic [15:0] len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_addr   = addr;
    bus.cmd_length = len;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic push_xfer(input logic [15:0] base, input int lines);
    exp_t e;
    for (int i = 0; i < lines; i++) begin
      e.addr = base + 16'(i * 4);
      e.data = dev_line(i, dev_seed);
      e.off  = 2'(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n = 0;
    while (!bus.dma_end && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 80'(bus.dma_end), 80'(1));
    @(negedge clk);
  endtask

  task automatic wait_write_rise(input int budget, input string tag);
    int n = 0;
    while (!bus.mem_write && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 80'(bus.mem_write), 80'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      80'(bus.busy),      80'(0));
    chk({tag, "_br"},        80'(bus.br),        80'(0));
    chk({tag, "_mem_write"}, 80'(bus.mem_write), 80'(0));
    chk({tag, "_dma_end"},   80'(bus.dma_end),   80'(0));
    chk({tag, "_cmd_error"}, 80'(bus.cmd_error), 80'(0));
    chk({tag, "_offset"},    80'(bus.offset),    80'(3));
    chk({tag, "_mem_addr"},  80'(bus.mem_addr),  80'(0));
    chk({tag, "_mem_wdata"}, 80'(bus.mem_wdata), 80'(0));
  endtask

  initial begin
    int e0;
    logic [15:0] bad_len [3];
    bad_len[0] = 16'd0;
    bad_len[1] = 16'd6;
    bad_len[2] = 16'd16;

    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_length = '0;
    bus.bg         = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // full three-line transfer, grant already present
    bus.bg    = 1'b1;
    ack_delay = 2;
    dev_seed  = 1;
    e0 = end_cnt;
    push_xfer(16'h01F4, 3);
    send_cmd(16'h01F4, 16'd12);
    chk("full_busy", 80'(bus.busy), 80'(1));
    chk("full_br", 80'(bus.br), 80'(1));
    wait_end(100, "full_end_timeout");
    chk("full_sb_empty", 80'(sb_q.size()), 80'(0));
    chk("full_end_count", 80'(end_cnt - e0), 80'(1));
    chk("full_idle_busy", 80'(bus.busy), 80'(0));

    // rejected lengths
    for (int i = 0; i < 3; i++) begin
      send_cmd(16'h0040, bad_len[i]);
      chk("inv_cmd_error", 80'(bus.cmd_error), 80'(1));
      chk("inv_br", 80'(bus.br), 80'(0));
      chk("inv_busy", 80'(bus.busy), 80'(0));
      chk("inv_mem_write", 80'(bus.mem_write), 80'(0));
      @(negedge clk);
      chk("inv_cmd_error_pulse", 80'(bus.cmd_error), 80'(0));
    end

    // late grant, then grant withdrawn during SETUP of line 1
    bus.bg    = 1'b0;
    ack_delay = 2;
    dev_seed  = 2;
    e0 = end_cnt;
    push_xfer(16'h0100, 2);
    send_cmd(16'h0100, 16'd8);
    chk("grant_br", 80'(bus.br), 80'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("grant_wait_nowrite", 80'(bus.mem_write), 80'(0));
    end
    bus.bg = 1'b1;
    wait_write_rise(20, "grant_write_timeout");
    repeat (2) @(negedge clk);
    chk("grant_setup1_offset", 80'(bus.offset), 80'(1));
    chk("grant_setup1_nowrite", 80'(bus.mem_write), 80'(0));
    bus.bg = 1'b0;
    @(negedge clk);
    chk("grant_req_br", 80'(bus.br), 80'(1));
    chk("grant_req_nowrite", 80'(bus.mem_write), 80'(0));
    @(negedge clk);
    chk("grant_req_hold", 80'(bus.mem_write), 80'(0));
    bus.bg = 1'b1;
    wait_end(100, "grant_end_timeout");
    chk("grant_sb_empty", 80'(sb_q.size()), 80'(0));
    chk("grant_end_count", 80'(end_cnt - e0), 80'(1));

    // stray ack in REQ, command while in WRITE
    bus.bg    = 1'b0;
    ack_delay = 3;
    dev_seed  = 3;
    e0 = end_cnt;
    push_xfer(16'h0200, 2);
    send_cmd(16'h0200, 16'd8);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_br", 80'(bus.br), 80'(1));
    chk("stray_nowrite", 80'(bus.mem_write), 80'(0));
    chk("stray_offset", 80'(bus.offset), 80'(3));
    bus.bg = 1'b1;
    wait_write_rise(20, "busy_write_timeout");
    send_cmd(16'h0500, 16'd4);
    chk("busy_cmd_error", 80'(bus.cmd_error), 80'(1));
    chk("busy_write_held", 80'(bus.mem_write), 80'(1));
    @(negedge clk);
    chk("busy_cmd_error_pulse", 80'(bus.cmd_error), 80'(0));
    wait_end(100, "busy_end_timeout");
    chk("busy_sb_empty", 80'(sb_q.size()), 80'(0));
    chk("busy_end_count", 80'(end_cnt - e0), 80'(1));

    // reset while writing line 0
    ack_delay = 4;
    dev_seed  = 4;
    e0 = end_cnt;
    push_xfer(16'h0300, 2);
    send_cmd(16'h0300, 16'd8);
    wait_write_rise(20, "rstmid_write_timeout");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rstmid");
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_abandoned", 80'(sb_q.size()), 80'(1));
    sb_q.delete();
    repeat (6) @(negedge clk);
    chk("rstmid_no_end", 80'(end_cnt - e0), 80'(0));
    chk("rstmid_idle_br", 80'(bus.br), 80'(0));
    dev_seed = 5;
    push_xfer(16'h0400, 1);
    send_cmd(16'h0400, 16'd4);
    wait_end(100, "rstmid_end_timeout");
    chk("rstmid_sb_empty", 80'(sb_q.size()), 80'(0));

    // address wrap past 0xFFFF
    ack_delay = 1;
    dev_seed  = 6;
    push_xfer(16'hFFFC, 2);
    send_cmd(16'hFFFC, 16'd8);
    wait_end(100, "wrap_end_timeout");
    chk("wrap_sb_empty", 80'(sb_q.size()), 80'(0));

    chk("total_end_count", 80'(end_cnt), 80'(5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
